// File: rtl/narrow_link_arbiter_pkg.sv
// Shared definitions for the narrow-link arbiter: FSM encoding and width helpers.
package narrow_link_arbiter_pkg;

  // Arbiter FSM encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  // Width of an index selecting one of n requesters (at least one bit)
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a beat counter spanning 0..len-1 (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned len);
    return (len > 1) ? $clog2(len) : 1;
  endfunction

  // Widths for the default configuration (4 requesters, 16-beat bursts)
  localparam int unsigned GRANT_W_DEF = idx_width(4);
  localparam int unsigned CNT_W_DEF   = cnt_width(16);

endpackage

// File: rtl/narrow_link_arbiter_rr_pick.sv
// Round-robin winner search: first set request at or above the pointer, wrapping to 0.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  logic         w_hi_any;
  logic [W-1:0] w_hi_idx;
  logic         w_lo_any;
  logic [W-1:0] w_lo_idx;

  // Two plain priority scans (at/above pointer, then from 0) replace a rotate-and-mod search
  always_comb begin
    w_hi_any = 1'b0;
    w_hi_idx = '0;
    w_lo_any = 1'b0;
    w_lo_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!w_hi_any && i_req[i] && (i >= 32'(i_ptr))) begin
        w_hi_any = 1'b1;
        w_hi_idx = W'(i);
      end
      if (!w_lo_any && i_req[i]) begin
        w_lo_any = 1'b1;
        w_lo_idx = W'(i);
      end
    end
    o_any = w_lo_any;
    o_idx = w_hi_any ? w_hi_idx : w_lo_idx;
  end

endmodule

// File: rtl/narrow_link_arbiter.sv
// Round-robin arbiter granting one narrow requester a fixed-length burst onto a shared link.
module narrow_link_arbiter
  import narrow_link_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    din,
  input  logic [NUM_REQ-1:0]               vld_in,
  output logic [NUM_REQ-1:0]               rdy_upward,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             vld_out,
  input  logic                             rdy_downward,
  output logic [idx_width(NUM_REQ)-1:0]    grant_id,
  output logic                             busy
);

  localparam int unsigned GW = idx_width(NUM_REQ);
  localparam int unsigned CW = cnt_width(BURST_LEN);

  logic [0:0]            r_state;
  logic [GW-1:0]         r_ptr;
  logic [GW-1:0]         r_grant;
  logic [CW-1:0]         r_cnt;

  logic [GW-1:0]         w_pick;
  logic                  w_any;
  logic                  w_xfer;
  logic                  w_src_vld;
  logic                  w_beat;
  logic                  w_last;
  logic [GW-1:0]         w_ptr_next;
  logic [DATA_WIDTH-1:0] w_words [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_words[g] = din[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(
    .N (NUM_REQ),
    .W (GW)
  ) u_pick (
    .i_req (vld_in),
    .i_ptr (r_ptr),
    .o_idx (w_pick),
    .o_any (w_any)
  );

  assign w_xfer     = (r_state == ST_XFER);
  assign w_src_vld  = vld_in[r_grant];
  assign w_beat     = w_xfer && w_src_vld && rdy_downward;
  assign w_last     = (r_cnt == CW'(BURST_LEN - 1));
  assign w_ptr_next = (r_grant == GW'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
  assign grant_id   = r_grant;
  assign busy       = w_xfer;

  // Zero-latency datapath: route the owner's word/valid down and ready up while in a burst
  always_comb begin
    dout       = '0;
    vld_out    = 1'b0;
    rdy_upward = '0;
    if (w_xfer) begin
      dout                = w_words[r_grant];
      vld_out             = w_src_vld;
      rdy_upward[r_grant] = rdy_downward;
    end
  end

  // FSM: arbitrate in IDLE, count beats in XFER, advance the pointer past the owner at burst end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_grant <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_grant <= w_pick;
            r_cnt   <= '0;
            r_state <= ST_XFER;
          end
        end
        default: begin
          if (w_beat) begin
            if (w_last) begin
              r_state <= ST_IDLE;
              r_ptr   <= w_ptr_next;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_narrow_link_arbiter.sv
// Directed self-checking bench for narrow_link_arbiter (16-beat and 1-beat configurations).
module tb_narrow_link_arbiter;

  localparam int NR = 4;
  localparam int DW = 32;
  localparam int BL = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NR*DW-1:0]  din;
  logic [NR-1:0]     vld_in, rdy_up, vld_in1, rdy_up1;
  logic [DW-1:0]     dout, dout1;
  logic              vld_out, vld_out1, rdy_dn, rdy_dn1, busy, busy1;
  logic [1:0]        gid, gid1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  narrow_link_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .din(din), .vld_in(vld_in), .rdy_upward(rdy_up),
    .dout(dout), .vld_out(vld_out), .rdy_downward(rdy_dn), .grant_id(gid), .busy(busy)
  );

  narrow_link_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .BURST_LEN(1)) dut1 (
    .clk(clk), .reset(reset), .din(din), .vld_in(vld_in1), .rdy_upward(rdy_up1),
    .dout(dout1), .vld_out(vld_out1), .rdy_downward(rdy_dn1), .grant_id(gid1), .busy(busy1)
  );

  function automatic logic [DW-1:0] word(input int i);
    return 32'hA5A5_0000 + 32'(i) * 32'h0000_1111;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    vld_in  = '0;
    vld_in1 = '0;
    rdy_dn  = 1'b1;
    rdy_dn1 = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Follow one burst on dut; optional downstream stall window and owner-valid gap window
  task automatic observe_burst(input int id, input int beats_exp,
                               input int stall_at, input int stall_len,
                               input int gap_at, input int gap_len, input bit rearm);
    int t = 0;
    int k = 0;
    int beats = 0;
    int bad = 0;
    logic [NR-1:0] base;
    logic [NR-1:0] exp_rdy;
    base = vld_in;
    while (!busy && t < 8) begin
      tick();
      t++;
    end
    chk("start", busy, 1);
    chk("grant_id", gid, id);
    while (busy && k < 200) begin
      rdy_dn = !(k >= stall_at && k < stall_at + stall_len);
      vld_in = base;
      if (k >= gap_at && k < gap_at + gap_len) vld_in[id] = 1'b0;
      #1;
      exp_rdy = '0;
      if (rdy_dn) exp_rdy[id] = 1'b1;
      if (dout !== word(id)) bad++;
      if (vld_out !== vld_in[id]) bad++;
      if (rdy_up !== exp_rdy) bad++;
      if (gid !== 2'(id)) bad++;
      if (vld_out && rdy_dn) beats++;
      tick();
      k++;
    end
    rdy_dn = 1'b1;
    vld_in = base;
    chk("beats", beats, beats_exp);
    chk("xfer_cycles", k, beats_exp + stall_len + gap_len);
    chk("datapath", bad, 0);
    chk("bubble_vld", vld_out, 0);
    chk("bubble_rdy", rdy_up, 0);
    chk("bubble_dout", dout, 0);
    chk("bubble_gid", gid, id);
    tick();
    chk("rearb", busy, rearm);
  endtask

  int eb [8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  int eg [8] = '{0, 0, 0, 1, 1, 0, 0, 1};

  initial begin
    for (int i = 0; i < NR; i++) din[i*DW +: DW] = word(i);

    // Reset held with requests pending: nothing may be granted
    reset   = 1'b1;
    vld_in  = 4'b1111;
    vld_in1 = 4'b1111;
    rdy_dn  = 1'b1;
    rdy_dn1 = 1'b1;
    tick();
    tick();
    chk("rst_vld", vld_out, 0);
    chk("rst_rdy", rdy_up, 0);
    chk("rst_dout", dout, 0);
    chk("rst_gid", gid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_busy1", busy1, 0);
    do_reset();

    // Single requester, back-to-back repeat grants
    vld_in = 4'b0100;
    observe_burst(2, 16, 999, 0, 999, 0, 1);
    observe_burst(2, 16, 999, 0, 999, 0, 1);
    do_reset();

    // All requesting: round-robin order 0,1,2,3,0
    vld_in = 4'b1111;
    observe_burst(0, 16, 999, 0, 999, 0, 1);
    observe_burst(1, 16, 999, 0, 999, 0, 1);
    observe_burst(2, 16, 999, 0, 999, 0, 1);
    observe_burst(3, 16, 999, 0, 999, 0, 1);
    observe_burst(0, 16, 999, 0, 999, 0, 1);
    do_reset();

    // Downstream stall for burst cycles 5..9
    vld_in = 4'b0001;
    observe_burst(0, 16, 5, 5, 999, 0, 1);
    do_reset();

    // Source gap on requester 1 while 3 also requests; pointer then moves to 3
    vld_in = 4'b1010;
    observe_burst(1, 16, 999, 0, 6, 3, 1);
    observe_burst(3, 16, 999, 0, 999, 0, 1);
    do_reset();

    // Reset at beat 7 of a burst to requester 3
    vld_in = 4'b1000;
    begin
      int t = 0;
      while (!busy && t < 8) begin
        tick();
        t++;
      end
    end
    chk("r34_gid", gid, 3);
    for (int i = 0; i < 7; i++) tick();
    chk("r34_busy", busy, 1);
    reset  = 1'b1;
    vld_in = 4'b1010;
    tick();
    chk("r34_vld", vld_out, 0);
    chk("r34_rdy", rdy_up, 0);
    chk("r34_idle", busy, 0);
    chk("r34_gid0", gid, 0);
    reset = 1'b0;
    tick();
    chk("r34_regrant", busy, 1);
    chk("r34_next", gid, 1);
    do_reset();

    // BURST_LEN=1: alternating single beats with one bubble each
    vld_in1 = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      chk("bl1_busy", busy1, eb[c]);
      chk("bl1_gid", gid1, eg[c]);
      chk("bl1_vld", vld_out1, eb[c]);
      if (eb[c] != 0) chk("bl1_dout", dout1, word(eg[c]));
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/narrow_link_arbiter.md
NARROW_LINK_ARBITER -- requirements
Module: narrow_link_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, number of narrow-word requesters (2..8).
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, narrow word width.
REQ-003 The block SHALL have parameter BURST_LEN, default 16, beats per grant (one unpacked 512-bit word), legal range 1..256.
REQ-004 The block SHALL have port clk, input, 1, clock; all logic on the rising edge.
REQ-005 The block SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 The block SHALL have port din, input, NUM_REQ*DATA_WIDTH, requester words, requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-007 The block SHALL have port vld_in, input, NUM_REQ, per-requester valid.
REQ-008 The block SHALL have port rdy_upward, output, NUM_REQ, per-requester ready.
REQ-009 The block SHALL have port dout, output, DATA_WIDTH, selected word.
REQ-010 The block SHALL have port vld_out, output, 1, downstream valid.
REQ-011 The block SHALL have port rdy_downward, input, 1, downstream ready.
REQ-012 The block SHALL have port grant_id, output, clog2(NUM_REQ), current owner index.
REQ-013 The block SHALL have port busy, output, 1, high while in XFER.

Function
REQ-014 States SHALL be IDLE and XFER; a beat is a cycle with vld_out && rdy_downward.
REQ-015 In IDLE, rdy_upward SHALL be all-zero, vld_out 0, dout 0.
REQ-016 In IDLE with any vld_in bit set, the block SHALL register the winner into grant_id, clear the beat counter and enter XFER the next cycle.
REQ-017 Winner SHALL be the first set vld_in bit at or after rr_ptr, searching upward with wrap from NUM_REQ-1 to 0.
REQ-018 In XFER, dout SHALL equal din of grant_id, vld_out SHALL equal vld_in[grant_id], and rdy_upward SHALL be one-hot at grant_id carrying rdy_downward; all other bits 0.
REQ-019 The beat counter SHALL increment by one per beat only; a deasserted vld_in[grant_id] or rdy_downward SHALL hold the counter and the grant.
REQ-020 On the beat where the counter equals BURST_LEN-1, the block SHALL return to IDLE and set rr_ptr to grant_id+1 modulo NUM_REQ.
REQ-021 Exactly one idle cycle (arbitration bubble) SHALL separate consecutive bursts, including repeat grants to the same requester.
REQ-022 A grant SHALL never be revoked before BURST_LEN beats, regardless of other requesters' vld_in.
REQ-023 With BURST_LEN=1 the first beat in XFER SHALL end the burst.
REQ-024 grant_id SHALL hold its last value in IDLE until the next arbitration.

Reset
REQ-025 Reset SHALL force state IDLE, rr_ptr 0, beat counter 0, grant_id 0, busy 0; hence vld_out 0, rdy_upward 0, dout 0.
REQ-026 Reset asserted mid-burst SHALL abandon the burst with no further beats; arbitration restarts from requester 0.

Structure
REQ-027 A shared package SHALL hold the IDLE/XFER state encoding and the clog2-based width constants for grant_id and the beat counter.
REQ-028 The winner search SHALL be one combinational sub-module rr_pick (inputs req vector and pointer; outputs index and any-valid).
REQ-029 All state, rr_ptr, grant_id and counter SHALL be registers; the datapath SHALL be combinational passthrough with zero added latency.

Verification
REQ-030 Single requester: vld_in=4'b0100 constant, rdy_downward=1 -> grant_id=2, 16 beats, 1 idle cycle, then 16 more beats to requester 2.
REQ-031 All requesting: vld_in=4'b1111 constant -> grant order 0,1,2,3,0, each exactly 16 beats, one bubble between.
REQ-032 Downstream stall: rdy_downward=0 for cycles 5..9 of a burst -> counter frozen, vld_out stays 1, dout stable, burst still exactly 16 beats.
REQ-033 Source gap: vld_in[1] drops for 3 cycles mid-burst while vld_in[3]=1 -> grant stays 1, vld_out 0 during gap, no beats counted.
REQ-034 Reset at beat 7 of a burst to requester 3 -> next cycle vld_out=0, rdy_upward=0; with vld_in=4'b1010 next grant is 1.
REQ-035 BURST_LEN=1, vld_in=4'b0011 -> alternating single beats 0,1,0,1 with one bubble each.
